ibex_multdiv_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the slow multiplier/divider. It accepts mult/div requests from two requesters (port 0: ID stage, port 1: auxiliary unit), grants one, and drives the multdiv enable, select, operator and operand inputs for the whole operation. It captures the result on the unit's valid and returns it over a per-port response handshake. Only one operation is in flight at a time.

---
 rtl/ibex_multdiv_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ibex_multdiv_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_arbiter.sv
// ibex_multdiv_arbiter: two-port arbiter and sequencer in front of the slow
// multiplier/divider. One operation is in flight at a time. The request is
// captured on accept and the multdiv inputs are driven from those registers
// until the unit signals valid. The result is then held for the owning port
// until that port takes it.
//
// Build option: define IBEX_MD_ARB_RR_EN for round-robin arbitration between
// the two ports. Left undefined, port 0 has fixed priority.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; the grant goes to the arbitration winner
// BUSY  | multdiv enabled with the captured operation; waits for md_valid_i
// RESP  | result held on rsp_result_o for the owner until rsp_ready_i
module ibex_multdiv_arbiter #(
    parameter logic ForceDataIndTiming = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [1:0][1:0]  req_op_i,
    input  logic [1:0][1:0]  req_signed_mode_i,
    input  logic [1:0][31:0] req_op_a_i,
    input  logic [1:0][31:0] req_op_b_i,
    input  logic [1:0]       req_dit_i,

    output logic [1:0]       rsp_valid_o,
    input  logic [1:0]       rsp_ready_i,
    output logic [31:0]      rsp_result_o,

    output logic             md_mult_en_o,
    output logic             md_div_en_o,
    output logic             md_mult_sel_o,
    output logic             md_div_sel_o,
    output logic [1:0]       md_operator_o,
    output logic [1:0]       md_signed_mode_o,
    output logic [31:0]      md_op_a_o,
    output logic [31:0]      md_op_b_o,
    output logic             md_data_ind_timing_o,
    output logic             md_ready_id_o,
    input  logic             md_valid_i,
    input  logic [31:0]      md_result_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q;
    logic [1:0]  signed_mode_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic        dit_q;
    logic        owner_q;
    logic [31:0] result_q;
    logic        winner;
    logic        accept;
    logic        is_mult;

`ifdef IBEX_MD_ARB_RR_EN
    logic        last_q;

    // Round-robin winner: on a tie the port that did not win last time goes.
    always_comb begin
        if (req_valid_i == 2'b11) begin
            winner = ~last_q;
        end else begin
            winner = ~req_valid_i[0];
        end
    end

    // Remember the most recently accepted port; port 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= winner;
        end
    end
`else
    // Fixed priority: port 1 only wins when port 0 is not requesting.
    assign winner = ~req_valid_i[0];
`endif

    assign accept  = (state_q == IDLE) && req_valid_i[winner];
    // MULL/MULH have a clear upper opcode bit; DIV/REM have it set.
    assign is_mult = ~op_q[1];

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture; these stay put outside BUSY so the data lines stay quiet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q          <= 2'b00;
            signed_mode_q <= 2'b00;
            op_a_q        <= 32'h0;
            op_b_q        <= 32'h0;
            dit_q         <= 1'b0;
            owner_q       <= 1'b0;
        end else if (accept) begin
            op_q          <= req_op_i[winner];
            signed_mode_q <= req_signed_mode_i[winner];
            op_a_q        <= req_op_a_i[winner];
            op_b_q        <= req_op_b_i[winner];
            dit_q         <= req_dit_i[winner] | ForceDataIndTiming;
            owner_q       <= winner;
        end
    end

    // Result capture on the unit's valid while the operation is in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q <= 32'h0;
        end else if ((state_q == BUSY) && md_valid_i) begin
            result_q <= md_result_i;
        end
    end

    // Next-state and handshake/enable outputs.
    always_comb begin
        state_d       = state_q;
        req_ready_o   = 2'b00;
        rsp_valid_o   = 2'b00;
        rsp_result_o  = 32'h0;
        md_mult_en_o  = 1'b0;
        md_div_en_o   = 1'b0;
        md_mult_sel_o = 1'b0;
        md_div_sel_o  = 1'b0;
        md_ready_id_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i != 2'b00) begin
                    req_ready_o[winner] = 1'b1;
                end
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                md_mult_en_o  = is_mult;
                md_mult_sel_o = is_mult;
                md_div_en_o   = ~is_mult;
                md_div_sel_o  = ~is_mult;
                md_ready_id_o = md_valid_i;
                if (md_valid_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o[owner_q] = 1'b1;
                rsp_result_o         = result_q;
                if (rsp_ready_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign md_operator_o        = op_q;
    assign md_signed_mode_o     = signed_mode_q;
    assign md_op_a_o            = op_a_q;
    assign md_op_b_o            = op_b_q;
    assign md_data_ind_timing_o = dit_q;

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Directed bench for ibex_multdiv_arbiter with a behavioural multdiv unit.
// Honours IBEX_MD_ARB_RR_EN for the arbitration expectations.
module tb_ibex_multdiv_arbiter;

    localparam logic [1:0] MULL = 2'd0;
    localparam logic [1:0] MULH = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] REM  = 2'd3;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][1:0]  req_op;
    logic [1:0][1:0]  req_sm;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0]       req_dit;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_result;
    logic             md_mult_en, md_div_en, md_mult_sel, md_div_sel;
    logic [1:0]       md_operator, md_signed_mode;
    logic [31:0]      md_op_a, md_op_b;
    logic             md_dit, md_ready_id, md_valid;
    logic [31:0]      md_result;

    int vectors = 0;
    int miscompares = 0;

    ibex_multdiv_arbiter #(.ForceDataIndTiming(1'b0)) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .req_valid_i          (req_valid),
        .req_ready_o          (req_ready),
        .req_op_i             (req_op),
        .req_signed_mode_i    (req_sm),
        .req_op_a_i           (req_a),
        .req_op_b_i           (req_b),
        .req_dit_i            (req_dit),
        .rsp_valid_o          (rsp_valid),
        .rsp_ready_i          (rsp_ready),
        .rsp_result_o         (rsp_result),
        .md_mult_en_o         (md_mult_en),
        .md_div_en_o          (md_div_en),
        .md_mult_sel_o        (md_mult_sel),
        .md_div_sel_o         (md_div_sel),
        .md_operator_o        (md_operator),
        .md_signed_mode_o     (md_signed_mode),
        .md_op_a_o            (md_op_a),
        .md_op_b_o            (md_op_b),
        .md_data_ind_timing_o (md_dit),
        .md_ready_id_o        (md_ready_id),
        .md_valid_i           (md_valid),
        .md_result_i          (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requesters must hold valid until ready.
    for (genvar i = 0; i < 2; i++) begin : g_hold
        assert property (@(posedge clk) disable iff (!rst_n)
                         req_valid[i] && !req_ready[i] |=> req_valid[i])
            else $error("FAIL req_valid[%0d] dropped without ready", i);
    end

    // Behavioural multdiv: fixed latency per operation, result from operands.
    logic [5:0]         m_cnt;
    int                 m_target;
    logic signed [32:0] m_ea, m_eb;
    logic signed [65:0] m_prod;

    always_comb begin
        m_ea   = {md_signed_mode[0] & md_op_a[31], md_op_a};
        m_eb   = {md_signed_mode[1] & md_op_b[31], md_op_b};
        m_prod = m_ea * m_eb;
        m_target  = 37;
        md_result = 32'h0;
        case (md_operator)
            MULL: begin
                md_result = m_prod[31:0];
                m_target  = (!md_dit && md_op_b <= 32'd1) ? 2 : 33;
            end
            MULH: begin
                md_result = m_prod[63:32];
                m_target  = 33;
            end
            default: begin
                if (md_op_b == 32'h0) begin
                    md_result = (md_operator == DIV) ? 32'hFFFF_FFFF : md_op_a;
                    m_target  = md_dit ? 37 : 2;
                end else if (md_signed_mode != 2'b00) begin
                    md_result = (md_operator == DIV) ? 32'($signed(md_op_a) / $signed(md_op_b))
                                                     : 32'($signed(md_op_a) % $signed(md_op_b));
                end else begin
                    md_result = (md_operator == DIV) ? md_op_a / md_op_b : md_op_a % md_op_b;
                end
            end
        endcase
        md_valid = (md_mult_en | md_div_en) && (int'(m_cnt) == m_target - 1);
    end

    // Multdiv cycle counter; idles when not enabled or on completion.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_cnt <= 6'd0;
        else if ((md_mult_en | md_div_en) && !md_valid) m_cnt <= m_cnt + 6'd1;
        else m_cnt <= 6'd0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation on port p from a negedge and return at a negedge
    // after the response handshake. exp_lat=0 skips the latency check.
    task automatic do_op(input int p, input logic [1:0] op, input logic [1:0] sm,
                         input logic [31:0] a, input logic [31:0] b, input logic dit,
                         input logic [31:0] exp_res, input int exp_lat,
                         input int hold, input logic early);
        int n;
        int cyc;
        logic is_mult;
        is_mult = (op == MULL) || (op == MULH);
        req_op[p] = op; req_sm[p] = sm; req_a[p] = a; req_b[p] = b;
        req_dit[p] = dit; req_valid[p] = 1'b1;
        if (early) rsp_ready[p] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[p] && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n == 50) begin
            chk("grant_timeout", 32'd0, 32'd1);
            return;
        end
        chk("ready_other", 32'(req_ready[1-p]), 32'd0);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk); #1; cyc++;
            if (cyc == 1) begin
                chk("busy_mult_en", 32'(md_mult_en), 32'(is_mult));
                chk("busy_div_en", 32'(md_div_en), 32'(!is_mult));
                chk("busy_operator", 32'(md_operator), 32'(op));
                chk("busy_sm", 32'(md_signed_mode), 32'(sm));
                chk("busy_op_a", md_op_a, a);
                chk("busy_op_b", md_op_b, b);
                chk("busy_dit", 32'(md_dit), 32'(dit));
                chk("busy_req_ready", 32'(req_ready), 32'd0);
            end
        end while (rsp_valid == 2'b00 && cyc < 100);
        if (exp_lat != 0) chk("latency", cyc, exp_lat);
        chk("rsp_owner", 32'(rsp_valid), 32'(2'b01 << p));
        chk("rsp_result", rsp_result, exp_res);
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                req_op[1-p] = MULL; req_sm[1-p] = 2'b00; req_a[1-p] = 32'd3;
                req_b[1-p] = 32'd1; req_dit[1-p] = 1'b0; req_valid[1-p] = 1'b1;
            end
            @(negedge clk); #1;
            chk("hold_result", rsp_result, exp_res);
            chk("hold_en", 32'({md_mult_en, md_div_en}), 32'd0);
            chk("hold_grant", 32'(req_ready), 32'd0);
        end
        rsp_ready[p] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[p] = 1'b0;
        @(negedge clk); #1;
        chk("rsp_done_valid", 32'(rsp_valid), 32'd0);
        chk("rsp_done_result", rsp_result, 32'd0);
    endtask

    int exp_seq[5];
    int ng;
    int cyc;
    logic g;

    initial begin
`ifdef IBEX_MD_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1, 0};
`else
        exp_seq = '{0, 0, 0, 0, 1};
`endif
        rst_n = 1'b0; req_valid = '0; req_op = '0; req_sm = '0;
        req_a = '0; req_b = '0; req_dit = '0; rsp_ready = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_en_sel", 32'({md_mult_en, md_div_en, md_mult_sel, md_div_sel, md_ready_id}), 32'd0);
        chk("rst_operator", 32'(md_operator), 32'(MULL));
        chk("rst_result", rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(0, MULL, 2'b00, 32'd7, 32'd6, 1'b0, 32'd42, 0, 0, 1'b0);
        do_op(0, MULL, 2'b00, 32'd9, 32'd1, 1'b0, 32'd9, 3, 0, 1'b0);
        do_op(1, DIV, 2'b11, 32'hFFFF_FFEC, 32'd3, 1'b0, 32'hFFFF_FFFA, 38, 0, 1'b0);
        do_op(1, REM, 2'b11, 32'hFFFF_FFEC, 32'd3, 1'b0, 32'hFFFF_FFFE, 38, 0, 1'b1);
        do_op(0, DIV, 2'b00, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 3, 0, 1'b0);
        do_op(0, DIV, 2'b00, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 38, 0, 1'b0);
        do_op(0, REM, 2'b00, 32'd5, 32'd0, 1'b0, 32'd5, 3, 0, 1'b0);
        do_op(0, MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 34, 5, 1'b0);
        do_op(1, MULL, 2'b00, 32'd3, 32'd1, 1'b0, 32'd3, 3, 0, 1'b0);

        // Fresh reset so the round-robin pointer starts from its reset value.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_op = '{MULL, MULL}; req_sm = '0; req_dit = '0;
        req_a[0] = 32'd11; req_b[0] = 32'd1;
        req_a[1] = 32'd22; req_b[1] = 32'd1;
        req_valid = 2'b11; rsp_ready = 2'b11;
        ng = 0; cyc = 0;
        while (ng < 5 && cyc < 400) begin
            #1;
            if (rsp_valid != 2'b00)
                chk("arb_rsp", rsp_result, rsp_valid[0] ? 32'd11 : 32'd22);
            if (req_ready != 2'b00) begin
                g = req_ready[1];
                chk($sformatf("grant%0d", ng), 32'(g), 32'(exp_seq[ng]));
                ng++;
                @(posedge clk); #1;
                if (ng >= 4) req_valid[g] = 1'b0;
            end
            @(negedge clk); cyc++;
        end
        if (ng < 5) chk("arb_timeout", ng, 5);
        cyc = 0;
        #1;
        while (rsp_valid == 2'b00 && cyc < 50) begin
            @(negedge clk); #1; cyc++;
        end
        chk("arb_last_rsp", rsp_result, exp_seq[4] == 1 ? 32'd22 : 32'd11);
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        @(negedge clk);

        // Async reset during a DIV.
        req_op[0] = DIV; req_sm[0] = 2'b00; req_a[0] = 32'd100; req_b[0] = 32'd7;
        req_dit[0] = 1'b0; req_valid[0] = 1'b1;
        #1;
        cyc = 0;
        while (!req_ready[0] && cyc < 20) begin
            @(negedge clk); #1; cyc++;
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("pre_rst_div_en", 32'(md_div_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en_sel", 32'({md_mult_en, md_div_en, md_mult_sel, md_div_sel, md_ready_id}), 32'd0);
        chk("mid_rst_operator", 32'(md_operator), 32'(MULL));
        chk("mid_rst_op_a", md_op_a, 32'd0);
        chk("mid_rst_valid_ready", 32'({rsp_valid, req_ready}), 32'd0);
        chk("mid_rst_result", rsp_result, 32'd0);
        chk("mid_rst_dit", 32'(md_dit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(0, MULL, 2'b00, 32'd3, 32'd3, 1'b0, 32'd9, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
